md_iter_unit: RTL and testbench

- Iterative 32-bit multiply/divide responder serving the EX stage start/ready handshake. EX holds `start` high and stalls until `ready`.
- Performs signed or unsigned MULT/MULTU as shift-add and DIV/DIVU as restoring division, one bit per cycle.
- Returns a 64-bit result: the product, or {remainder, quotient}. EX routes it to HI/LO.

---
 rtl/md_iter_unit.sv | 121 ++++++++++++
 tb/tb_md_iter_unit.sv | 129 ++++++++++++
 2 files changed

// File: rtl/md_iter_unit.sv
// Iterative multiply/divide unit for the EX stage: shift-add MULT/MULTU and
// restoring DIV/DIVU, one bit per cycle, with a start/ready handshake.
module md_iter_unit #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               div_e,
  input  logic               e_signed,
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
  input  logic               start,
  output logic [2*WIDTH-1:0] result,
  output logic               ready,
  output logic               busy
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state, state_n;
  logic [CW-1:0]    count;
  logic             mode_div, neg_q, neg_r, div0;
  logic [WIDTH-1:0] x_orig;
  // acc is the upper product half or the remainder; lo is the multiplier
  // or the quotient; opb is the multiplicand or the divisor.
  logic [WIDTH-1:0] acc, lo, opb;

  logic             last;
  logic [WIDTH-1:0] x_abs, y_abs;
  logic [WIDTH:0]   mul_sum, rem_sh;
  logic             rem_ge;
  logic [WIDTH-1:0] acc_n, lo_n;
  logic [2*WIDTH-1:0] prod, fixed;

  assign last  = (count == CW'(WIDTH-1));
  assign busy  = (state == CALC);
  // abs of the most negative value wraps to itself, which is the intended
  // unsigned magnitude.
  assign x_abs = (e_signed && x[WIDTH-1]) ? -x : x;
  assign y_abs = (e_signed && y[WIDTH-1]) ? -y : y;

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = CALC;
      CALC:    if (!start) state_n = IDLE;
               else if (last) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    mul_sum = {1'b0, acc} + (lo[0] ? {1'b0, opb} : '0);
    rem_sh  = {acc, lo[WIDTH-1]};
    rem_ge  = (rem_sh >= {1'b0, opb});
    if (mode_div) begin
      acc_n = rem_ge ? WIDTH'(rem_sh - {1'b0, opb}) : rem_sh[WIDTH-1:0];
      lo_n  = {lo[WIDTH-2:0], rem_ge};
    end else begin
      acc_n = mul_sum[WIDTH:1];
      lo_n  = {mul_sum[0], lo[WIDTH-1:1]};
    end
    prod = {acc_n, lo_n};
    if (div0)
      fixed = {x_orig, {WIDTH{1'b1}}};
    else if (mode_div)
      fixed = {(neg_r ? -acc_n : acc_n), (neg_q ? -lo_n : lo_n)};
    else
      fixed = neg_q ? -prod : prod;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count    <= '0;
      result   <= '0;
      ready    <= 1'b0;
      mode_div <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div0     <= 1'b0;
      x_orig   <= '0;
      acc      <= '0;
      lo       <= '0;
      opb      <= '0;
    end else begin
      ready <= 1'b0;
      case (state)
        IDLE: if (start) begin
          mode_div <= div_e;
          neg_q    <= e_signed & (x[WIDTH-1] ^ y[WIDTH-1]);
          neg_r    <= e_signed & x[WIDTH-1];
          div0     <= div_e & (y == '0);
          x_orig   <= x;
          acc      <= '0;
          count    <= '0;
          lo       <= div_e ? x_abs : y_abs;
          opb      <= div_e ? y_abs : x_abs;
        end
        CALC: if (start) begin
          acc   <= acc_n;
          lo    <= lo_n;
          count <= count + 1'b1;
          if (last) begin
            result <= fixed;
            ready  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_md_iter_unit.sv
// Directed self-checking bench for md_iter_unit: latency, results, sign
// rules, divide by zero, abort, reset and back-to-back issue.
module tb_md_iter_unit;

  logic        clk = 1'b0;
  logic        rst, div_e, e_signed, start;
  logic [31:0] x, y;
  logic [63:0] result;
  logic        ready, busy;

  int checks = 0;
  int failures = 0;

  md_iter_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .div_e(div_e), .e_signed(e_signed),
    .x(x), .y(y), .start(start), .result(result), .ready(ready), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic d, input logic s, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    div_e = d; e_signed = s; x = a; y = b; start = 1'b1;
  endtask

  // Counts edges from accept until ready is seen, and cycles busy was high.
  task automatic wait_ready(output int n, output int nb);
    n = 0; nb = 0;
    while (n < 100) begin
      @(posedge clk); #1;
      n++;
      if (ready) break;
      if (busy) nb++;
    end
  endtask

  task automatic run_op(input string tag, input logic d, input logic s,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp);
    int n, nb;
    issue(d, s, a, b);
    wait_ready(n, nb);
    chk({tag, "_lat"}, 64'(n), 64'd33);
    chk({tag, "_busy"}, 64'(nb), 64'd32);
    chk(tag, result, exp);
    @(negedge clk) start = 1'b0;
    @(posedge clk); #1;
    chk({tag, "_rdy_low"}, 64'(ready), 64'd0);
    chk({tag, "_hold"}, result, exp);
  endtask

  initial begin
    int n, nb, pulses;
    rst = 1'b1; start = 1'b0; div_e = 1'b0; e_signed = 1'b0; x = '0; y = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_result", result, 64'd0);
    chk("rst_ready", 64'(ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    @(negedge clk) rst = 1'b0;

    run_op("multu_max", 1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001);
    run_op("mult_neg",  1'b0, 1'b1, 32'hFFFFFFFD, 32'd7,        64'hFFFFFFFF_FFFFFFEB);
    run_op("div_neg",   1'b1, 1'b1, 32'hFFFFFFF9, 32'd2,        64'hFFFFFFFF_FFFFFFFD);
    run_op("div_ovf",   1'b1, 1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000);
    run_op("divu_100",  1'b1, 1'b0, 32'd100,      32'd7,        64'h00000002_0000000E);
    run_op("divu_5_9",  1'b1, 1'b0, 32'd5,        32'd9,        64'h00000005_00000000);
    run_op("div0_u",    1'b1, 1'b0, 32'h12345678, 32'd0,        64'h12345678_FFFFFFFF);
    run_op("div0_s",    1'b1, 1'b1, 32'h12345678, 32'd0,        64'h12345678_FFFFFFFF);

    // Abort after 10 CALC cycles: back to IDLE, no ready, result held.
    issue(1'b0, 1'b0, 32'd3, 32'd4);
    repeat (11) @(posedge clk);
    @(negedge clk) start = 1'b0;
    @(posedge clk); #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_ready", 64'(ready), 64'd0);
    chk("abort_hold", result, 64'h12345678_FFFFFFFF);
    pulses = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (ready) pulses++;
    end
    chk("abort_nopulse", 64'(pulses), 64'd0);

    // Reset mid-CALC.
    issue(1'b0, 1'b0, 32'd3, 32'd4);
    repeat (6) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    chk("rstcalc_result", result, 64'd0);
    chk("rstcalc_ready", 64'(ready), 64'd0);
    chk("rstcalc_busy", 64'(busy), 64'd0);
    @(negedge clk) begin rst = 1'b0; start = 1'b0; end

    // Back-to-back: start held across DONE; second op accepted after DONE.
    issue(1'b0, 1'b0, 32'd6, 32'd7);
    wait_ready(n, nb);
    chk("b2b_lat1", 64'(n), 64'd33);
    chk("b2b_res1", result, 64'h00000000_0000002A);
    div_e = 1'b1; e_signed = 1'b0; x = 32'd42; y = 32'd5;
    n = 0;
    while (n < 100) begin
      @(posedge clk); #1;
      n++;
      if (ready) break;
      if (n == 12) begin
        div_e = 1'b0; e_signed = 1'b1; x = 32'hDEADBEEF; y = 32'h0;
      end
    end
    chk("b2b_interval", 64'(n), 64'd34);
    chk("b2b_res2", result, 64'h00000002_00000008);
    @(negedge clk) start = 1'b0;
    @(posedge clk); #1;
    chk("b2b_rdy_low", 64'(ready), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
